alu_seq: RTL and testbench

Parametrised, registered successor to the combinational data-processing ALU. Executes the 16 ARM data-processing opcodes at any `WIDTH`, keeps NZCV in an architectural flag register updated only on S-bit or compare ops, and moves operands and results over valid/ready handshakes. An optional iterative MUL/MLA unit is compiled in. Sits between the register-read/shifter stage and writeback in the core datapath.

---
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ARM data-processing ALU with NZCV flag register and valid/ready handshakes
// Optional iterative MUL/MLA shift-add unit compiled in with ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             set_flags,
  input  logic             mul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             sh_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_wr,
  output logic [3:0]       nzcv
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_s_q, mul_s_d;
`else
  typedef enum logic {S_IDLE, S_HOLD} state_t;
  logic unused_mul;
  assign unused_mul = ^{mul, c};
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             res_wr_q, res_wr_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       nzcv_q, nzcv_d;

  logic             accept;
  logic [WIDTH-1:0] x, y, lres, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, arith, alu_c, alu_v;

  assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign res_wr    = res_wr_q;
  assign nzcv      = nzcv_q;

  // Every add/subtract is x + y + cin, with subtracts folded into an inverted operand.
  always_comb begin
    x     = a;
    y     = b;
    cin   = 1'b0;
    arith = 1'b1;
    case (op)
      4'h2, 4'hA: begin y = ~b; cin = 1'b1; end
      4'h3:       begin x = b; y = ~a; cin = 1'b1; end
      4'h4, 4'hB: cin = 1'b0;
      4'h5:       cin = nzcv_q[1];
      4'h6:       begin y = ~b; cin = nzcv_q[1]; end
      4'h7:       begin x = b; y = ~a; cin = nzcv_q[1]; end
      default:    arith = 1'b0;
    endcase
    case (op)
      4'h0, 4'h8: lres = a & b;
      4'h1, 4'h9: lres = a ^ b;
      4'hC:       lres = a | b;
      4'hD:       lres = b;
      4'hE:       lres = a & ~b;
      4'hF:       lres = ~b;
      default:    lres = '0;
    endcase
    sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    alu_res = arith ? sum[WIDTH-1:0] : lres;
    alu_c   = arith ? sum[WIDTH] : sh_c;
    alu_v   = arith ? ((x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1])) : nzcv_q[0];
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    res_wr_d    = res_wr_q;
    out_valid_d = out_valid_q;
    nzcv_d      = nzcv_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_s_d  = mul_s_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (mul) begin
            state_d  = S_MUL;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = op[0] ? c : '0;
            cnt_d    = '0;
            mul_s_d  = set_flags;
          end else begin
`else
          begin
`endif
            result_d    = alu_res;
            res_wr_d    = (op[3:2] != 2'b10);
            out_valid_d = 1'b1;
            if (set_flags || op[3:2] == 2'b10)
              nzcv_d = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last partial product lands straight in the result register.
        if (cnt_q == CW'(WIDTH - 1)) begin
          result_d    = acc_d;
          res_wr_d    = 1'b1;
          out_valid_d = 1'b1;
          if (mul_s_q) nzcv_d[3:2] = {acc_d[WIDTH-1], acc_d == '0};
          state_d     = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      res_wr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      nzcv_q      <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_s_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      res_wr_q    <= res_wr_d;
      out_valid_q <= out_valid_d;
      nzcv_q      <= nzcv_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_s_q  <= mul_s_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=32
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, in_ready;
  logic [3:0]   op = 4'h0;
  logic         set_flags = 1'b0, mul = 1'b0, sh_c = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] result;
  logic         res_wr;
  logic [3:0]   nzcv;

  int n_checks = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .set_flags(set_flags), .mul(mul), .a(a), .b(b), .c(c), .sh_c(sh_c),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .res_wr(res_wr), .nzcv(nzcv)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] o, input logic s, input logic m,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] cc, input logic shc);
    in_valid = 1'b1; op = o; set_flags = s; mul = m; a = aa; b = bb; c = cc; sh_c = shc;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_result: got %h want 0", result); end
    n_checks++; if ({res_wr, nzcv} !== 5'b0) begin n_fail++; $display("FAIL rst_reswr_nzcv: got %b want 00000", {res_wr, nzcv}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_overflow;
    drive(4'h4, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h1, '0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
    n_checks++; if (result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result: got %h want 80000000", result); end
    n_checks++; if ({res_wr, nzcv} !== 5'b1_1001) begin n_fail++; $display("FAIL ovf_nzcv: got %b want 11001", {res_wr, nzcv}); end
    step;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drop: got %b want 0", out_valid); end
  endtask

  task automatic test_carry_chain;
    drive(4'h4, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h1, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'h0, 4'b0110}) begin n_fail++; $display("FAIL adds_carry: got %h/%b want 0/0110", result, nzcv); end
    drive(4'h5, 1'b0, 1'b0, 32'h1, 32'h1, '0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, result, nzcv} !== {1'b1, 32'h3, 4'b0110}) begin n_fail++; $display("FAIL adc_b2b: got %b/%h/%b want 1/3/0110", out_valid, result, nzcv); end
  endtask

  task automatic test_compare;
    drive(4'hA, 1'b0, 1'b0, 32'h3, 32'h5, '0, 1'b0);
    step;
    n_checks++; if ({res_wr, result, nzcv} !== {1'b0, 32'hFFFF_FFFE, 4'b1000}) begin n_fail++; $display("FAIL cmp: got %b/%h/%b want 0/fffffffe/1000", res_wr, result, nzcv); end
    drive(4'h2, 1'b1, 1'b0, 32'h5, 32'h5, '0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if ({res_wr, result, nzcv} !== {1'b1, 32'h0, 4'b0110}) begin n_fail++; $display("FAIL subs_zero: got %b/%h/%b want 1/0/0110", res_wr, result, nzcv); end
  endtask

  task automatic test_logic_and_sub;
    drive(4'h2, 1'b1, 1'b0, 32'h8000_0000, 32'h1, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'h7FFF_FFFF, 4'b0011}) begin n_fail++; $display("FAIL subs_ovf: got %h/%b want 7fffffff/0011", result, nzcv); end
    drive(4'h8, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, '0, 1'b0);
    step;
    n_checks++; if ({res_wr, nzcv} !== 5'b0_1001) begin n_fail++; $display("FAIL tst_keepv: got %b want 01001", {res_wr, nzcv}); end
    drive(4'hF, 1'b1, 1'b0, '0, 32'h0, '0, 1'b1);
    step;
    n_checks++; if ({result, nzcv} !== {32'hFFFF_FFFF, 4'b1011}) begin n_fail++; $display("FAIL mvns: got %h/%b want ffffffff/1011", result, nzcv); end
    drive(4'h3, 1'b1, 1'b0, 32'h1, 32'h0, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'hFFFF_FFFF, 4'b1000}) begin n_fail++; $display("FAIL rsbs_borrow: got %h/%b want ffffffff/1000", result, nzcv); end
    drive(4'h6, 1'b0, 1'b0, 32'd10, 32'd3, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'd6, 4'b1000}) begin n_fail++; $display("FAIL sbc_c0: got %h/%b want 6/1000", result, nzcv); end
    drive(4'h7, 1'b1, 1'b0, 32'd1, 32'd5, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'd3, 4'b0010}) begin n_fail++; $display("FAIL rscs_c0: got %h/%b want 3/0010", result, nzcv); end
    drive(4'hE, 1'b1, 1'b0, 32'hFF, 32'h0F, '0, 1'b0);
    step;
    n_checks++; if ({result, nzcv} !== {32'hF0, 4'b0000}) begin n_fail++; $display("FAIL bics: got %h/%b want f0/0000", result, nzcv); end
    drive(4'h9, 1'b0, 1'b0, 32'h5, 32'h5, '0, 1'b1);
    step;
    in_valid = 1'b0;
    n_checks++; if ({res_wr, nzcv} !== 5'b0_0110) begin n_fail++; $display("FAIL teq: got %b want 00110", {res_wr, nzcv}); end
  endtask

  task automatic test_backpressure;
    int bad;
    drive(4'hC, 1'b0, 1'b0, 32'hF0, 32'h0F, '0, 1'b0);
    step;
    out_ready = 1'b0;
    drive(4'h4, 1'b0, 1'b0, 32'h10, 32'h20, '0, 1'b0);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid !== 1'b1 || result !== 32'hFF || in_ready !== 1'b0) bad++;
      step;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    n_checks++; if ({out_valid, result} !== {1'b1, 32'hFF}) begin n_fail++; $display("FAIL bp_held: got %b/%h want 1/ff", out_valid, result); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, result} !== {1'b1, 32'h30}) begin n_fail++; $display("FAIL bp_next: got %b/%h want 1/30", out_valid, result); end
    step;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b want 0", out_valid); end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_multiply;
    int bad;
    int waited;
    drive(4'hB, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, '0, 1'b0);
    step;
    n_checks++; if (nzcv !== 4'b0111) begin n_fail++; $display("FAIL cmn_pre: got %b want 0111", nzcv); end
    drive(4'h1, 1'b1, 1'b1, 32'h1_0000, 32'h1_0000, 32'h5, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mla_ready: got %b want 1", in_ready); end
    @(posedge clk);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk);
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mla_busy: got %0d early/ready cycles want 0", bad); end
    @(negedge clk);
    n_checks++; if ({out_valid, res_wr, result} !== {2'b11, 32'h5}) begin n_fail++; $display("FAIL mla_result: got %b%b/%h want 11/5", out_valid, res_wr, result); end
    n_checks++; if (nzcv !== 4'b0011) begin n_fail++; $display("FAIL mla_flags: got %b want 0011", nzcv); end
    step;
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL mla_drain: got %b want 10", {in_ready, out_valid}); end
    drive(4'h0, 1'b1, 1'b1, 32'h1_0000, 32'h1_0000, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL muls_timeout: got %b want 1", out_valid); end
    n_checks++; if ({result, nzcv} !== {32'h0, 4'b0111}) begin n_fail++; $display("FAIL muls_zero: got %h/%b want 0/0111", result, nzcv); end
    step;
  endtask

  task automatic test_reset_mid_op;
    int bad;
    drive(4'h0, 1'b0, 1'b1, 32'h3, 32'h4, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, res_wr, nzcv} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_mul: got %b want 000000", {out_valid, res_wr, nzcv}); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    drive(4'h4, 1'b0, 1'b0, 32'h2, 32'h2, '0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, result} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL rst_mid_add: got %b/%h want 1/4", out_valid, result); end
    bad = 0;
    for (int k = 0; k < 36; k++) begin
      step;
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst_mid_ghost: got %0d stray valid cycles want 0", bad); end
  endtask
`else
  task automatic test_multiply;
    drive(4'h4, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h7, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, result, nzcv} !== {1'b1, 32'h0, 4'b0110}) begin n_fail++; $display("FAIL mul_ignored: got %b/%h/%b want 1/0/0110", out_valid, result, nzcv); end
  endtask

  task automatic test_reset_mid_op;
    drive(4'hC, 1'b0, 1'b1, 32'h1, 32'h2, '0, 1'b0);
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step;
    n_checks++; if ({out_valid, result} !== {1'b1, 32'h3}) begin n_fail++; $display("FAIL orr_held: got %b/%h want 1/3", out_valid, result); end
    rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, res_wr, nzcv} !== 6'b0) begin n_fail++; $display("FAIL rst_mid_hold: got %b want 000000", {out_valid, res_wr, nzcv}); end
    n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    drive(4'h4, 1'b0, 1'b0, 32'h2, 32'h2, '0, 1'b0);
    step;
    in_valid = 1'b0;
    n_checks++; if ({out_valid, result} !== {1'b1, 32'h4}) begin n_fail++; $display("FAIL rst_mid_add: got %b/%h want 1/4", out_valid, result); end
  endtask
`endif

  initial begin
    test_reset;
    test_overflow;
    test_carry_chain;
    test_compare;
    test_logic_and_sub;
    test_backpressure;
    test_multiply;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
